// File: rtl/decode_stage.sv
// RV32I decode stage: register-read, writeback bypass (DECODE_WB_BYPASS_EN), immediate, load-use stall; 1-cycle latency
// into ID/EX, which holds while ex_ready is low; if_ready drops on flush, hazard, writeback conflict or a full ID/EX.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    output logic [4:0]      rf_read_reg1,
    output logic [4:0]      rf_read_reg2,
    input  logic [XLEN-1:0] rf_read_data1,
    input  logic [XLEN-1:0] rf_read_data2,
    input  logic            wb_write_enable,
    input  logic [4:0]      wb_write_reg,
    input  logic [XLEN-1:0] wb_write_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        K_R, K_I, K_S, K_B, K_U, K_J, K_F, K_X
    } kind_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            illegal;
    } idex_t;

    idex_t           idex_q;
    idex_t           idex_d;
    kind_t           kind;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            writes_rd;
    logic            hazard;
    logic            wb_hit1;
    logic            wb_hit2;
    logic            wb_stall;
    logic            accept;

    assign opcode       = if_instr[6:0];
    assign rs1          = if_instr[19:15];
    assign rs2          = if_instr[24:20];
    assign rf_read_reg1 = rs1;
    assign rf_read_reg2 = rs2;

    always_comb begin
        kind = K_X;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: kind = K_I;
            OP_STORE:                            kind = K_S;
            OP_BRANCH:                           kind = K_B;
            OP_LUI, OP_AUIPC:                    kind = K_U;
            OP_JAL:                              kind = K_J;
            OP_REG:                              kind = K_R;
            OP_FENCE:                            kind = K_F;
            default:                             kind = K_X;
        endcase
    end

    always_comb begin
        imm = '0;
        case (kind)
            K_I:     imm = {{20{if_instr[31]}}, if_instr[31:20]};
            K_S:     imm = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            K_B:     imm = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
            K_U:     imm = {if_instr[31:12], 12'b0};
            K_J:     imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign uses_rs1  = (kind != K_U) && (kind != K_J);
    assign uses_rs2  = (kind == K_R) || (kind == K_S) || (kind == K_B);
    assign writes_rd = (kind == K_R) || (kind == K_I) || (kind == K_U) || (kind == K_J);

    // A load still in ID/EX has no data yet; its consumer must wait for it to leave.
    assign hazard = ex_valid && (idex_q.opcode == OP_LOAD) && (idex_q.rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == idex_q.rd)) || (uses_rs2 && (rs2 == idex_q.rd)));

    assign wb_hit1 = wb_write_enable && (wb_write_reg == rs1) && (rs1 != 5'd0);
    assign wb_hit2 = wb_write_enable && (wb_write_reg == rs2) && (rs2 != 5'd0);

`ifdef DECODE_WB_BYPASS_EN
    assign wb_stall = 1'b0;
    assign op1 = (rs1 == 5'd0) ? '0 : (wb_hit1 ? wb_write_data : rf_read_data1);
    assign op2 = (rs2 == 5'd0) ? '0 : (wb_hit2 ? wb_write_data : rf_read_data2);
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_write_data;
    // Without a bypass the register file returns the new value one cycle later.
    assign wb_stall = (uses_rs1 && wb_hit1) || (uses_rs2 && wb_hit2);
    assign op1 = (rs1 == 5'd0) ? '0 : rf_read_data1;
    assign op2 = (rs2 == 5'd0) ? '0 : rf_read_data2;
`endif

    assign if_ready = !reset && !flush && !hazard && !wb_stall && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;

    always_comb begin
        idex_d          = '0;
        idex_d.pc       = if_pc;
        idex_d.rs1_data = op1;
        idex_d.rs2_data = op2;
        idex_d.imm      = imm;
        idex_d.rs1      = rs1;
        idex_d.rs2      = rs2;
        idex_d.rd       = writes_rd ? if_instr[11:7] : 5'd0;
        idex_d.opcode   = opcode;
        idex_d.funct3   = if_instr[14:12];
        idex_d.funct7   = if_instr[31:25];
        idex_d.illegal  = (kind == K_X);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q   <= '0;
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            idex_q   <= idex_d;
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_pc       = idex_q.pc;
    assign ex_rs1_data = idex_q.rs1_data;
    assign ex_rs2_data = idex_q.rs2_data;
    assign ex_imm      = idex_q.imm;
    assign ex_rs1      = idex_q.rs1;
    assign ex_rs2      = idex_q.rs2;
    assign ex_rd       = idex_q.rd;
    assign ex_opcode   = idex_q.opcode;
    assign ex_funct3   = idex_q.funct3;
    assign ex_funct7   = idex_q.funct7;
    assign ex_illegal  = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage against a spec-level reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, if_valid, if_ready;
    logic [31:0] if_pc, if_instr;
    logic [4:0]  rf_read_reg1, rf_read_reg2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic        wb_write_enable;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode, ex_funct7;
    logic [2:0]  ex_funct3;
    logic        ex_illegal;

    decode_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .wb_write_enable(wb_write_enable), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    localparam int KR = 0, KI = 1, KS = 2, KB = 3, KU = 4, KJ = 5, KF = 6, KX = 7;

    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    logic m_valid;
    logic m_zero;
    exp_t m_ex;
    logic exp_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int kind_of(input logic [6:0] o);
        case (o)
            7'h03, 7'h13, 7'h67, 7'h73: return KI;
            7'h23: return KS;
            7'h63: return KB;
            7'h37, 7'h17: return KU;
            7'h6F: return KJ;
            7'h33: return KR;
            7'h0F: return KF;
            default: return KX;
        endcase
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic [31:0] i;
        logic signed [11:0] s12;
        logic signed [19:0] s20;
        int k;
        i = if_instr;
        k = kind_of(i[6:0]);
        e.pc  = if_pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.opc = i[6:0];
        e.f3  = i[14:12];
        e.f7  = i[31:25];
        e.ill = (k == KX);
        e.rd  = (k == KR || k == KI || k == KU || k == KJ) ? i[11:7] : 5'd0;
        case (k)
            KI: begin s12 = i[31:20]; e.imm = int'(s12); end
            KS: begin s12 = {i[31:25], i[11:7]}; e.imm = int'(s12); end
            KB: begin s12 = {i[31], i[7], i[30:25], i[11:8]}; e.imm = int'(s12) * 2; end
            KU: e.imm = i & 32'hFFFFF000;
            KJ: begin s20 = {i[31], i[19:12], i[20], i[30:21]}; e.imm = int'(s20) * 2; end
            default: e.imm = 32'd0;
        endcase
        e.d1 = rf_read_data1;
        e.d2 = rf_read_data2;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_write_enable && wb_write_reg == e.rs1) e.d1 = wb_write_data;
        if (wb_write_enable && wb_write_reg == e.rs2) e.d2 = wb_write_data;
`endif
        if (e.rs1 == 0) e.d1 = 0;
        if (e.rs2 == 0) e.d2 = 0;
        return e;
    endfunction

    function automatic logic model_ready();
        int  k;
        logic r1, r2, load_block, wb_block;
        k  = kind_of(if_instr[6:0]);
        r1 = !(k == KU || k == KJ);
        r2 = (k == KR || k == KS || k == KB);
        load_block = m_valid && m_ex.opc == 7'h03 && m_ex.rd != 0 &&
                     ((r1 && if_instr[19:15] == m_ex.rd) || (r2 && if_instr[24:20] == m_ex.rd));
        wb_block = 1'b0;
`ifndef DECODE_WB_BYPASS_EN
        wb_block = wb_write_enable && wb_write_reg != 0 &&
                   ((r1 && wb_write_reg == if_instr[19:15]) || (r2 && wb_write_reg == if_instr[24:20]));
`endif
        return !reset && !flush && !load_block && !wb_block && (!m_valid || ex_ready);
    endfunction

    task automatic cycle();
        @(negedge clk);
        exp_ready = model_ready();
        check("if_ready", {31'd0, if_ready}, {31'd0, exp_ready});
        check("rf_read_reg1", {27'd0, rf_read_reg1}, {27'd0, if_instr[19:15]});
        check("rf_read_reg2", {27'd0, rf_read_reg2}, {27'd0, if_instr[24:20]});
        if (reset) begin
            m_valid = 1'b0;
            m_zero  = 1'b1;
            m_ex    = '{default: 0};
        end else if (flush) begin
            m_valid = 1'b0;
            m_zero  = 1'b0;
        end else if (if_valid && exp_ready) begin
            m_ex    = predict();
            m_valid = 1'b1;
            m_zero  = 1'b0;
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        if (m_valid || m_zero) begin
            check("ex_pc", ex_pc, m_ex.pc);
            check("ex_rs1_data", ex_rs1_data, m_ex.d1);
            check("ex_rs2_data", ex_rs2_data, m_ex.d2);
            check("ex_imm", ex_imm, m_ex.imm);
            check("ex_rs1", {27'd0, ex_rs1}, {27'd0, m_ex.rs1});
            check("ex_rs2", {27'd0, ex_rs2}, {27'd0, m_ex.rs2});
            check("ex_rd", {27'd0, ex_rd}, {27'd0, m_ex.rd});
            check("ex_opcode", {25'd0, ex_opcode}, {25'd0, m_ex.opc});
            check("ex_funct3", {29'd0, ex_funct3}, {29'd0, m_ex.f3});
            check("ex_funct7", {25'd0, ex_funct7}, {25'd0, m_ex.f7});
            check("ex_illegal", {31'd0, ex_illegal}, {31'd0, m_ex.ill});
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12];
        logic [31:0] i;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F, 7'h7F};
        i = $urandom;
        if ($urandom_range(0, 9) != 0) i[6:0] = ops[$urandom_range(0, 11)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        return i;
    endfunction

    initial begin
        m_valid = 1'b0;
        m_zero  = 1'b1;
        m_ex    = '{default: 0};
        reset = 1'b1; flush = 1'b0; if_valid = 1'b1; if_pc = 32'h0; if_instr = 32'hFFF00293;
        rf_read_data1 = 32'h0; rf_read_data2 = 32'h0; wb_write_enable = 1'b0;
        wb_write_reg = 5'd0; wb_write_data = 32'h0; ex_ready = 1'b1;

        // reset held three cycles with a valid instruction offered
        repeat (3) cycle();
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_ex_imm", ex_imm, 32'd0);

        // addi x5,x0,-1 at 0x100; rf port 1 data must be ignored for x0
        reset = 1'b0; if_pc = 32'h100; rf_read_data1 = 32'h55AA55AA;
        cycle();
        check("addi_imm", ex_imm, 32'hFFFFFFFF);
        check("addi_rd", {27'd0, ex_rd}, 32'd5);
        check("addi_rs1_data", ex_rs1_data, 32'd0);
        check("addi_pc", ex_pc, 32'h100);

        // add x3,x1,x2 with writeback of x1 in the same cycle
        if_pc = 32'h104; if_instr = 32'h002081B3; rf_read_data1 = 32'h0; rf_read_data2 = 32'h22;
        wb_write_enable = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'hDEADBEEF;
        cycle();
`ifndef DECODE_WB_BYPASS_EN
        check("wb_stall_bubble", {31'd0, ex_valid}, 32'd0);
        wb_write_enable = 1'b0; rf_read_data1 = 32'hDEADBEEF;
        cycle();
`endif
        wb_write_enable = 1'b0;
        check("add_rs1_data", ex_rs1_data, 32'hDEADBEEF);

        // lw x7,0(x1) then add x8,x7,x7: one bubble
        if_pc = 32'h108; if_instr = 32'h0000A383;
        cycle();
        if_pc = 32'h10C; if_instr = 32'h00738433;
        cycle();
        check("load_use_bubble", {31'd0, ex_valid}, 32'd0);
        cycle();
        check("load_use_rd", {27'd0, ex_rd}, 32'd8);

        // backpressure for four cycles, then drain
        if_pc = 32'h110; if_instr = 32'h00500493; ex_ready = 1'b0;
        repeat (4) cycle();
        check("held_rd", {27'd0, ex_rd}, 32'd8);
        ex_ready = 1'b1;
        cycle();
        check("after_bp_rd", {27'd0, ex_rd}, 32'd9);

        // flush during a load-use stall with execute back-pressured
        if_pc = 32'h114; if_instr = 32'h0000A383;
        cycle();
        if_pc = 32'h118; if_instr = 32'h00738433; ex_ready = 1'b0; flush = 1'b1;
        cycle();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        flush = 1'b0; ex_ready = 1'b1;

        // illegal opcode 0x7F with a nonzero rd field
        if_pc = 32'h200; if_instr = 32'h0000057F;
        cycle();
        check("illegal_flag", {31'd0, ex_illegal}, 32'd1);
        check("illegal_rd", {27'd0, ex_rd}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            flush           = ($urandom_range(0, 29) == 0);
            if_valid        = ($urandom_range(0, 3) != 0);
            ex_ready        = ($urandom_range(0, 3) != 0);
            if_pc           = $urandom & 32'hFFFFFFFC;
            if_instr        = rand_instr();
            rf_read_data1   = $urandom;
            rf_read_data2   = $urandom;
            wb_write_enable = $urandom_range(0, 1) == 1;
            wb_write_reg    = 5'($urandom_range(0, 3));
            wb_write_data   = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
